uart_rcv_interface: RTL
=======================

// Module: uart_rcv_interface
// PURPOSE
//  Serial receiver, companion to the team's UART transmit interface. Samples rx_line in the clk domain, decodes
//  8N1 frames (start, 8 data LSB-first, stop), holds each byte in a one-entry buffer until the consumer
//  (rcv FIFO / command decoder) takes it, and flags framing and overrun errors.
// PARAMETERS
//  CLK_DIV    16   clk cycles per bit period; min 4; counter width = $clog2(CLK_DIV)
//  SYNC_STAGES 2   flops in rx_line synchronizer; min 2
// PORTS
//  clk        in   1  system clock; all logic single clock domain
//  rst_n      in   1  asynchronous active-low reset
//  rx_line    in   1  serial input, idle high, asynchronous to clk
//  rx_ack     in   1  consumer takes rx_data; sampled only while rx_valid=1
//  rx_data    out  8  received byte, stable while rx_valid=1
//  rx_valid   out  1  byte available; held until rx_ack
//  rx_busy    out  1  high from start-edge detect until return to IDLE
//  frame_err  out  1  sticky; stop bit sampled 0; cleared by rx_ack
//  overrun    out  1  sticky; frame completed while rx_valid=1; cleared by rx_ack
//  parity_err out  1  see CONFIGURATION; 0 when macro undefined
// BEHAVIOUR
//  - Reset: state=IDLE, rx_data=8'h00, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0,
//    synchronizer flops=1 (line treated idle). Reset mid-frame discards partial byte; no rx_valid.
//  - rs = synchronized rx_line (SYNC_STAGES cycles latency). All decisions use rs only.
//  - FSM: IDLE -> START on rs falling edge (rs=0, previous=1); bit counter cleared, rx_busy=1.
//    START: after CLK_DIV/2 cycles sample rs; 0 -> DATA (counter restart); 1 -> IDLE (glitch reject, no flags).
//    DATA: sample every CLK_DIV cycles (mid-bit), shift in LSB-first; after bit 7 -> PARITY (macro) else STOP.
//    PARITY: one mid-bit sample -> STOP.  STOP: one mid-bit sample, then -> IDLE same cycle; no wait for
//    full stop period, so back-to-back frames with 1 stop bit are accepted.
//  - Completion (stop sample cycle): if rx_valid=0: rx_data<=shift reg, rx_valid<=1 next cycle;
//    frame_err<=~rs; parity_err per macro. If rx_valid=1: overrun<=1, rx_data unchanged, new byte dropped.
//  - Latency: rx_valid rises 1 clk after stop mid-sample, i.e. ~9.5*CLK_DIV + SYNC_STAGES + 1 clks after the
//    falling edge on rx_line.
//  - Handshake: rx_valid=1 & rx_ack=1 -> rx_valid, frame_err, overrun, parity_err cleared next cycle.
//    Completion and ack in same cycle: ack clears old byte, new byte loaded, rx_valid stays 1, no overrun.
//  - rx_ack while rx_valid=0 ignored. Frame with frame_err still delivers byte (consumer decides).
//  - rs held low (break): frame completes with frame_err=1, data 8'h00; FSM waits in IDLE for rs=1 before
//    accepting a new falling edge.
//  - rx_busy deasserts the cycle FSM re-enters IDLE.
// CONFIGURATION
//  PARITY_CHECK_EN defined: frame = start, 8 data, parity, stop. Even parity matching transmitter
//    (parity bit = ^data). parity_err<=(sample != ^data) at completion, sticky, cleared with rx_ack;
//    overrun case does not update it.
//  PARITY_CHECK_EN undefined: no PARITY state; parity_err tied 0; frame = 10 bits.
// TESTING (CLK_DIV=16, SYNC_STAGES=2)
//  1 Send 8'hA5, 1 stop -> rx_data=8'hA5, rx_valid=1, frame_err=0; ack -> rx_valid=0 next clk.
//  2 Send 8'h3C then 8'hC3 back-to-back, no ack -> rx_data=8'h3C, overrun=1; ack clears both.
//  3 Low pulse of 5 clks on idle line -> returns IDLE, rx_busy pulses, rx_valid=0, no flags.
//  4 Send 8'h55 with stop bit forced 0 -> rx_data=8'h55, frame_err=1; ack clears.
//  5 PARITY_CHECK_EN: 8'h07 with parity 1 -> parity_err=0; parity 0 -> parity_err=1.
//  6 Assert rst_n=0 at data bit 4 of 8'hFF, release, send 8'h12 -> only 8'h12 delivered, all flags 0.

Source files
------------

// File: rtl/uart_rcv_interface.sv
`default_nettype none
// ============================================================================
// Module   : uart_rcv_interface
// Brief    : 8N1 serial receiver with one-entry hold buffer, framing/overrun
//            flags; optional even-parity check when PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rcv_interface #(
    parameter int CLK_DIV     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_line,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int              CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]   FULL_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs_prev_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   rs;

    // Synchronizer resets to ones so the line looks idle out of reset.
    assign rs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            rs_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_line};
            rs_prev_q <= rs;
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_q, par_d;
    logic perr_q, perr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
`ifdef PARITY_CHECK_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif

        if (valid_q && rx_ack) begin
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef PARITY_CHECK_EN
            perr_d  = 1'b0;
`endif
        end

        case (state_q)
            S_IDLE: begin
                // A line held low keeps rs_prev_q at 0, so no new frame starts until rs returns high.
                if (!rs && rs_prev_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = rs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef PARITY_CHECK_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    par_d   = rs;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    // A same-cycle ack frees the buffer, so the new byte is taken instead of overrunning.
                    if (!valid_q || rx_ack) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = ~rs;
`ifdef PARITY_CHECK_EN
                        perr_d  = (par_q != ^shift_q);
`endif
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q != S_IDLE);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
`default_nettype wire
